nor3_sweep_ctrl: RTL and testbench

//   Self-checking stimulus sequencer for the 3-input NOR gate (norgate).
//   On start, drives all 8 {a,b,c} combinations into the gate, holds each for

---
 rtl/nor3_sweep_ctrl.sv | 114 +++++++++++
 tb/tb_nor3_sweep_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nor3_sweep_ctrl.sv
// Sweeps all eight {a,b,c} vectors through an external 3-input NOR gate and
// checks its output, reporting per-vector failures, a mismatch count and a verdict.
module nor3_sweep_ctrl #(
  parameter int unsigned HoldCycles = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       dut_y_i,
  output logic       dut_a_o,
  output logic       dut_b_o,
  output logic       dut_c_o,
  output logic       y_exp_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_count_o,
  output logic [7:0] fail_vec_o
);

  localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             pass_q, pass_d;
  logic [3:0]       err_q, err_d;
  logic [7:0]       fail_q, fail_d;

  logic             sample;
  logic             mismatch;
  logic [3:0]       err_inc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      hold_q  <= '0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fail_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // The gate is combinational, so y is compared on the last edge of each hold window.
  // An X/Z on y counts as a mismatch.
  always_comb begin
    sample   = (state_q == StRun) && (hold_q == HoldLast);
    mismatch = sample && (dut_y_i !== (~|idx_q));
    err_inc  = (mismatch && (err_q != 4'd8)) ? err_q + 4'd1 : err_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          idx_d   = 3'd0;
          hold_d  = '0;
          err_d   = 4'd0;
          fail_d  = 8'h00;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        if (sample) begin
          hold_d = '0;
          err_d  = err_inc;
          if (mismatch) fail_d[idx_q] = 1'b1;
          if (idx_q == 3'd7) begin
            state_d = StDone;
            pass_d  = (err_inc == 4'd0);
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = 3'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o                      = (state_q == StRun);
    done_o                      = (state_q == StDone);
    {dut_a_o, dut_b_o, dut_c_o} = busy_o ? idx_q : 3'b000;
    y_exp_o                     = busy_o ? ~|idx_q : 1'b1;
    pass_o                      = pass_q;
    err_count_o                 = err_q;
    fail_vec_o                  = fail_q;
  end

endmodule

// File: tb/tb_nor3_sweep_ctrl.sv
// Bench for nor3_sweep_ctrl: a HoldCycles=5 instance driven against several gate
// models, and a HoldCycles=1 instance with start held high.
module tb_nor3_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pass;
    logic [3:0] err;
    logic [7:0] fv;
  } res_t;

  typedef struct packed {
    logic [2:0] mode;
    logic       inject;
    res_t       exp;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic       rst_na = 1'b1, start_a = 1'b0, y_a;
  logic       a_a, b_a, c_a, yexp_a, busy_a, done_a, pass_a;
  logic [3:0] err_a;
  logic [7:0] fail_a;
  logic [2:0] mode = 3'd0;

  logic       rst_nb = 1'b1, start_b = 1'b0, y_b;
  logic       a_b, b_b, c_b, yexp_b, busy_b, done_b, pass_b;
  logic [3:0] err_b;
  logic [7:0] fail_b;

  res_t qa[$];
  res_t qb[$];
  res_t ea, eb;
  vec_t tbl[6];

  nor3_sweep_ctrl #(.HoldCycles(5)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_na), .start_i(start_a), .dut_y_i(y_a),
    .dut_a_o(a_a), .dut_b_o(b_a), .dut_c_o(c_a), .y_exp_o(yexp_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .err_count_o(err_a), .fail_vec_o(fail_a)
  );

  nor3_sweep_ctrl #(.HoldCycles(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .start_i(start_b), .dut_y_i(y_b),
    .dut_a_o(a_b), .dut_b_o(b_b), .dut_c_o(c_b), .y_exp_o(yexp_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .err_count_o(err_b), .fail_vec_o(fail_b)
  );

  // Gate models: 0 NOR, 1 stuck-at-0, 2 OR, 3 stuck-at-1, 4 NOR wrong only at vector 5
  always_comb begin
    y_a = ~(a_a | b_a | c_a);
    case (mode)
      3'd1:    y_a = 1'b0;
      3'd2:    y_a = a_a | b_a | c_a;
      3'd3:    y_a = 1'b1;
      3'd4:    y_a = ({a_a, b_a, c_a} == 3'd5) ? 1'b1 : ~(a_a | b_a | c_a);
      default: y_a = ~(a_a | b_a | c_a);
    endcase
  end
  assign y_b = ~(a_b | b_b | c_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboards: each done pulse pops one expected verdict.
  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL done_a_unexpected: got done=1 want 0");
      end else begin
        ea = qa.pop_front();
        chk("sb_pass_a", 32'(pass_a), 32'(ea.pass));
        chk("sb_err_a", 32'(err_a), 32'(ea.err));
        chk("sb_fail_a", 32'(fail_a), 32'(ea.fv));
      end
    end
    if (done_b) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL done_b_unexpected: got done=1 want 0");
      end else begin
        eb = qb.pop_front();
        chk("sb_pass_b", 32'(pass_b), 32'(eb.pass));
        chk("sb_err_b", 32'(err_b), 32'(eb.err));
        chk("sb_fail_b", 32'(fail_b), 32'(eb.fv));
      end
    end
  end

  task automatic check_reset_a(input string tag);
    chk({tag, "_abc"}, 32'({a_a, b_a, c_a}), 32'd0);
    chk({tag, "_yexp"}, 32'(yexp_a), 32'd1);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
    chk({tag, "_pass"}, 32'(pass_a), 32'd0);
    chk({tag, "_err"}, 32'(err_a), 32'd0);
    chk({tag, "_fail"}, 32'(fail_a), 32'd0);
  endtask

  // One HoldCycles=5 sweep; returns at the negedge after the DONE-state edge plus 3 idle cycles.
  task automatic sweep_a(input vec_t v);
    logic [2:0] k;
    mode = v.mode;
    qa.push_back(v.exp);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int n = 0; n < 40; n++) begin
      k = 3'(n / 5);
      chk("run_abc_a", 32'({a_a, b_a, c_a}), 32'(k));
      chk("run_busy_a", 32'(busy_a), 32'd1);
      if (n % 5 == 0) chk("run_yexp_a", 32'(yexp_a), 32'(~|k));
      start_a = (v.inject && (n == 3 || n == 20)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    chk("done_a", 32'(done_a), 32'd1);
    chk("done_busy_a", 32'(busy_a), 32'd0);
    chk("done_abc_a", 32'({a_a, b_a, c_a}), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_busy_a", 32'(busy_a), 32'd0);
    chk("hold_pass_a", 32'(pass_a), 32'(v.exp.pass));
    chk("hold_err_a", 32'(err_a), 32'(v.exp.err));
    chk("hold_fail_a", 32'(fail_a), 32'(v.exp.fv));
  endtask

  initial begin
    tbl[0] = '{mode: 3'd0, inject: 1'b0, exp: '{pass: 1'b1, err: 4'd0, fv: 8'h00}};
    tbl[1] = '{mode: 3'd1, inject: 1'b0, exp: '{pass: 1'b0, err: 4'd1, fv: 8'h01}};
    tbl[2] = '{mode: 3'd2, inject: 1'b0, exp: '{pass: 1'b0, err: 4'd8, fv: 8'hFF}};
    tbl[3] = '{mode: 3'd3, inject: 1'b0, exp: '{pass: 1'b0, err: 4'd7, fv: 8'hFE}};
    tbl[4] = '{mode: 3'd4, inject: 1'b0, exp: '{pass: 1'b0, err: 4'd1, fv: 8'h20}};
    tbl[5] = '{mode: 3'd0, inject: 1'b1, exp: '{pass: 1'b1, err: 4'd0, fv: 8'h00}};

    #1 rst_na = 1'b0; rst_nb = 1'b0;
    #1 check_reset_a("rst");
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_na = 1'b1; rst_nb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy_a", 32'(busy_a), 32'd0);
      chk("idle_abc_a", 32'({a_a, b_a, c_a}), 32'd0);
    end

    for (int i = 0; i < 6; i++) sweep_a(tbl[i]);

    // Reset during vector 4 of a failing sweep: no done, counters cleared at once.
    mode = 3'd2;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (21) @(negedge clk);
    chk("mid_abc_a", 32'({a_a, b_a, c_a}), 32'd4);
    chk("mid_err_a", 32'(err_a), 32'd4);
    #2 rst_na = 1'b0;
    #1 check_reset_a("midrst");
    @(negedge clk);
    check_reset_a("midrst_hold");
    rst_na = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_busy_a", 32'(busy_a), 32'd0);
    end
    sweep_a(tbl[0]);

    // HoldCycles=1 with start held high: 10-cycle period, three sweeps.
    repeat (3) qb.push_back('{pass: 1'b1, err: 4'd0, fv: 8'h00});
    @(negedge clk);
    start_b = 1'b1;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      if (n < 30) begin
        if (n % 10 < 8) begin
          chk("b_abc", 32'({a_b, b_b, c_b}), 32'(n % 10));
          chk("b_busy", 32'(busy_b), 32'd1);
        end else if (n % 10 == 8) begin
          chk("b_done", 32'(done_b), 32'd1);
        end else begin
          chk("b_idle_busy", 32'(busy_b), 32'd0);
          chk("b_idle_done", 32'(done_b), 32'd0);
        end
      end else begin
        chk("b_stop_busy", 32'(busy_b), 32'd0);
      end
      if (n == 28) start_b = 1'b0;
    end

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
